// File: rtl/csa_seq_ctrl_if.sv
// Request/response bundle between the ALU front end and the nibble-serial adder sequencer.
// The master drives requests and accepts results; the slave (sequencer) does the reverse.
interface csa_seq_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, c_in, out_ready,
    input  in_ready, out_valid, result, c_out, zero, ovf
  );

  modport slave (
    input  in_valid, op, a, b, c_in, out_ready,
    output in_ready, out_valid, result, c_out, zero, ovf
  );
endinterface

// File: rtl/csa_seq_ctrl.sv
// Runs one external 4-bit adder slice over WIDTH-bit ADD/SUB operands, one nibble per clock.
// Optional zero/overflow flags are built when CSA_SEQ_FLAGS_EN is defined; otherwise they read 0.
module csa_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  csa_seq_ctrl_if.slave bus,
  output logic [3:0]    add_a,
  output logic [3:0]    add_b,
  output logic [1:0]    add_mode,
  output logic          add_cin,
  input  logic [3:0]    add_sum,
  input  logic          add_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic in_ready_int;
  logic out_valid_int;
  logic accept;
  logic run_step;
  logic last_step;

  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign run_step  = (state_reg == RUN);
  assign last_step = run_step && (idx_reg == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: handshakes and the adder slice, which is held at zero outside RUN
  always_comb begin
    in_ready_int  = (state_reg == IDLE);
    out_valid_int = (state_reg == DONE);
    add_a         = 4'h0;
    add_b         = 4'h0;
    add_cin       = 1'b0;
    add_mode      = 2'b00;
    if (state_reg == RUN) begin
      add_a   = opa_reg[4*idx_reg +: 4];
      add_b   = opb_reg[4*idx_reg +: 4];
      add_cin = carry_reg;
    end
  end

  // SUB is B inverted with the chain seeded by 1; the slice always runs in plain add mode.
  always_comb begin
    idx_next   = idx_reg;
    carry_next = carry_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    if (accept) begin
      opa_next   = bus.a;
      opb_next   = bus.op ? ~bus.b : bus.b;
      carry_next = bus.op | bus.c_in;
      idx_next   = '0;
    end else if (run_step) begin
      carry_next = add_cout;
      if (!last_step) begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nibble
      assign result_next[4*gi +: 4] =
        accept ? 4'h0 :
        (run_step && (idx_reg == IDX_W'(gi))) ? add_sum :
        result_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
    end else begin
      idx_reg    <= idx_next;
      carry_reg  <= carry_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      result_reg <= result_next;
    end
  end

`ifdef CSA_SEQ_FLAGS_EN
  logic zero_reg;
  logic ovf_reg;

  // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (last_step) begin
      zero_reg <= ~|result_next;
      ovf_reg  <= (opa_reg[WIDTH-1] ^ opb_reg[WIDTH-1] ^ add_sum[3]) ^ add_cout;
    end
  end

  assign bus.zero = zero_reg;
  assign bus.ovf  = ovf_reg;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.result    = result_reg;
  assign bus.c_out     = carry_reg;

endmodule
